// File: rtl/fpga_input_entry.sv
// rtl/fpga_input_entry.sv - synchronized, debounced decimal digit entry with valid/ready output
//
// Ports:
//   clk          system clock, all registers on rising edge
//   rst_n        asynchronous active-low reset
//   sw[3:0]      BCD digit switches (asynchronous)
//   key_enter_n  enter pushbutton, active-low (asynchronous)
//   key_clear_n  clear pushbutton, active-low (asynchronous)
//   value        completed entry, binary
//   value_valid  completed entry is offered
//   value_ready  consumer accepts the offered entry
//   entry_value  running accumulator for display echo
//   digit_count  digits accepted in the current entry
//   digit_error  sticky: last enter press saw a non-decimal switch code
module fpga_input_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIGITS          = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic        key_enter_n,
    input  logic        key_clear_n,
    output logic [31:0] value,
    output logic        value_valid,
    input  logic        value_ready,
    output logic [31:0] entry_value,
    output logic [3:0]  digit_count,
    output logic        digit_error
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    DIGIT_MAX = 4'(DIGITS);

    typedef enum logic {COLLECT = 1'b0, OFFER = 1'b1} state_t;

    // Key vectors: index 0 = enter, index 1 = clear.
    logic [3:0]    sw_s1, sw_s2;
    logic [1:0]    key_s1, key_s2;
    logic [1:0]    key_lvl, key_lvl_d, key_p;
    logic [CW-1:0] key_cnt [2];

    logic enter_p, clear_p;
    assign enter_p = key_p[0];
    assign clear_p = key_p[1];

    // Synchronizers, debouncers and press-edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1      <= 4'd0;
            sw_s2      <= 4'd0;
            key_s1     <= 2'b11;
            key_s2     <= 2'b11;
            key_lvl    <= 2'b11;
            key_lvl_d  <= 2'b11;
            key_p      <= 2'b00;
            key_cnt[0] <= '0;
            key_cnt[1] <= '0;
        end else begin
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            key_s1    <= {key_clear_n, key_enter_n};
            key_s2    <= key_s1;
            key_lvl_d <= key_lvl;
            // Pulse is registered, so it appears the cycle after the level falls.
            key_p     <= key_lvl_d & ~key_lvl;
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] != key_lvl[i]) begin
                    if (key_cnt[i] == CNT_MAX) begin
                        key_lvl[i] <= ~key_lvl[i];
                        key_cnt[i] <= '0;
                    end else begin
                        key_cnt[i] <= key_cnt[i] + 1'b1;
                    end
                end else begin
                    key_cnt[i] <= '0;
                end
            end
        end
    end

    state_t      state, state_next;
    logic [31:0] acc;
    logic [3:0]  count_inc;
    logic        bad_digit, good_digit, entry_done, transfer;
    logic [31:0] acc_next;

    assign count_inc = digit_count + 4'd1;
    assign acc_next  = acc * 32'd10 + {28'd0, sw_s2};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (entry_done) state_next = OFFER;
            OFFER:   if (transfer)   state_next = COLLECT;
            default:                 state_next = COLLECT;
        endcase
    end

    // Output / decode logic. Clear wins over a coincident enter.
    always_comb begin
        value_valid = (state == OFFER);
        bad_digit   = (state == COLLECT) && !clear_p && enter_p && (sw_s2 > 4'd9);
        good_digit  = (state == COLLECT) && !clear_p && enter_p && (sw_s2 <= 4'd9);
        entry_done  = good_digit && (count_inc == DIGIT_MAX);
        transfer    = (state == OFFER) && value_ready;
    end

    // Entry datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= 32'd0;
            digit_count <= 4'd0;
            digit_error <= 1'b0;
            value       <= 32'd0;
        end else begin
            if ((state == COLLECT) && clear_p) begin
                acc         <= 32'd0;
                digit_count <= 4'd0;
                digit_error <= 1'b0;
            end else if (bad_digit) begin
                digit_error <= 1'b1;
            end else if (good_digit) begin
                acc         <= acc_next;
                digit_count <= count_inc;
                digit_error <= 1'b0;
                if (entry_done) value <= acc_next;
            end else if (transfer) begin
                acc         <= 32'd0;
                digit_count <= 4'd0;
            end
        end
    end

    assign entry_value = acc;

endmodule

// File: tb/tb_fpga_input_entry.sv
// tb/tb_fpga_input_entry.sv - self-checking bench for fpga_input_entry
module tb_fpga_input_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic        key_enter_n;
    logic        key_clear_n;
    logic [31:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;
    logic        digit_error;

    fpga_input_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
        .value(value), .value_valid(value_valid), .value_ready(value_ready),
        .entry_value(entry_value), .digit_count(digit_count),
        .digit_error(digit_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model of the entry rules.
    int unsigned m_acc;
    int unsigned m_cnt;
    bit          m_err;
    bit          m_offer;
    int unsigned m_pending;
    int unsigned exp_q[$];
    logic [31:0] got_q[$];
    int          valid_cycles;

    always @(negedge clk) begin
        if (rst_n) begin
            if (value_valid) valid_cycles++;
            if (value_valid && value_ready) got_q.push_back(value);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_acc = 0; m_cnt = 0; m_err = 0; m_offer = 0;
    endtask

    task automatic m_enter(input int unsigned d);
        if (m_offer) return;
        if (d > 9) begin
            m_err = 1;
        end else begin
            m_acc = m_acc * 10 + d;
            m_cnt++;
            m_err = 0;
            if (m_cnt == 2) begin
                if (value_ready) begin
                    exp_q.push_back(m_acc);
                    m_acc = 0; m_cnt = 0;
                end else begin
                    m_offer = 1; m_pending = m_acc;
                end
            end
        end
    endtask

    task automatic m_clear();
        if (m_offer) return;
        m_acc = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic press(input bit ent, input bit clr);
        @(negedge clk);
        key_enter_n = ~ent;
        key_clear_n = ~clr;
        repeat (12) @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".entry_value"}, entry_value, m_acc);
        check({tag, ".digit_count"}, {28'd0, digit_count}, m_cnt);
        check({tag, ".digit_error"}, {31'd0, digit_error}, {31'd0, m_err});
    endtask

    task automatic check_transfers(input string tag);
        while (exp_q.size() > 0) begin
            check({tag, ".have_transfer"}, {31'd0, got_q.size() > 0}, 32'd1);
            if (got_q.size() == 0) begin
                void'(exp_q.pop_front());
            end else begin
                check({tag, ".value"}, got_q.pop_front(), exp_q.pop_front());
            end
        end
        check({tag, ".no_extra"}, got_q.size(), 32'd0);
        got_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; sw = 4'd0; key_enter_n = 1'b1; key_clear_n = 1'b1;
        value_ready = 1'b1; valid_cycles = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset.value", value, 32'd0);
        check("reset.value_valid", {31'd0, value_valid}, 32'd0);
        check_model("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic entry with exact latency on the first press.
        sw = 4'd4;
        key_enter_n = 1'b0;
        repeat (7) @(posedge clk);
        #1 check("latency.before", {28'd0, digit_count}, 32'd0);
        @(posedge clk);
        #1 check("latency.at", {28'd0, digit_count}, 32'd1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        m_enter(4);
        check_model("basic.d1");
        valid_cycles = 0;
        sw = 4'd2; press(1, 0); m_enter(2);
        check_model("basic.d2");
        check("basic.valid_cycles", valid_cycles, 32'd1);
        check_transfers("basic");

        // Bounce rejection: 2-cycle toggling then a solid hold.
        sw = 4'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); key_enter_n = 1'b0;
            @(negedge clk); key_enter_n = 1'b1;
        end
        @(negedge clk); key_enter_n = 1'b0;
        repeat (12) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        m_enter(6);
        check_model("bounce");

        // Clear the partial entry, then invalid digit handling.
        press(0, 1); m_clear();
        check_model("clear");
        sw = 4'd12; press(1, 0); m_enter(12);
        check_model("invalid");
        sw = 4'd7; press(1, 0); m_enter(7);
        check_model("invalid.recover");
        press(0, 1); m_clear();

        // Clear priority over a coincident enter.
        sw = 4'd3; press(1, 0); m_enter(3);
        check_model("prio.d1");
        sw = 4'd5; press(1, 1); m_clear();
        check_model("prio");
        check_transfers("prio");

        // Backpressure.
        value_ready = 1'b0;
        sw = 4'd9; press(1, 0); m_enter(9);
        press(1, 0); m_enter(9);
        check("bp.valid", {31'd0, value_valid}, 32'd1);
        check("bp.value", value, 32'd99);
        check_model("bp.offer");
        sw = 4'd5; press(1, 0); m_enter(5);
        for (int i = 0; i < 5; i++) begin
            repeat (5) @(negedge clk);
            check("bp.hold_valid", {31'd0, value_valid}, 32'd1);
            check("bp.hold_value", value, 32'd99);
        end
        check_model("bp.ignored");
        value_ready = 1'b1;
        @(negedge clk);
        if (m_offer) begin
            exp_q.push_back(m_pending);
            m_offer = 0; m_acc = 0; m_cnt = 0;
        end
        check("bp.valid_after", {31'd0, value_valid}, 32'd0);
        check_model("bp.after");
        check_transfers("bp");

        // Randomized entries checked against the model.
        for (int i = 0; i < 12; i++) begin
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                press(0, 1); m_clear();
            end else begin
                press(1, 0); m_enter(int'(sw));
            end
            check_model("rand");
        end
        check_transfers("rand");

        // Reset while an offer is pending.
        press(0, 1); m_clear();
        value_ready = 1'b0;
        sw = 4'd1; press(1, 0); m_enter(1);
        sw = 4'd2; press(1, 0); m_enter(2);
        check("rst.valid_before", {31'd0, value_valid}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("rst.valid_async", {31'd0, value_valid}, 32'd0);
        check("rst.value", value, 32'd0);
        check_model("rst");
        got_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        value_ready = 1'b1;
        repeat (2) @(negedge clk);
        sw = 4'd8; press(1, 0); m_enter(8);
        check_model("rst.collect");
        check_transfers("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_input_entry.md
# fpga_input_entry

Board-side input front end for the MIPS FPGA build: the reverse of the seven-segment output path. It synchronizes and debounces the DE2 pushbuttons and the digit switches, and assembles multi-digit decimal entries into a 32-bit binary value. Each completed value is offered to the processor side over a valid/ready handshake. A running accumulator is exported so the display path can echo the digits as they are typed.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range ≥ 1
- DIGITS, 2, decimal digits per entry; legal range 1..9 (max 999,999,999 fits 32 bits)
- clk  input  1  system clock; every register is clocked on its rising edge
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk
- sw  input  4  BCD digit switches, asynchronous to clk
- key_enter_n  input  1  enter pushbutton, active-low, asynchronous
- key_clear_n  input  1  clear pushbutton, active-low, asynchronous
- value  output  32  completed entry, binary
- value_valid  output  1  value is held and offered
- value_ready  input  1  consumer accepts value
- entry_value  output  32  running accumulator, for display echo
- digit_count  output  4  digits accepted in the current entry
- digit_error  output  1  sticky flag: last enter press saw sw > 9

## Operation
- Input conditioning: `sw`, `key_enter_n` and `key_clear_n` each pass through a 2-flop synchronizer. Each key has its own debouncer.
- Debouncer: holds a debounced level (reset value 1) and a counter. The counter increments while the synchronized input differs from the debounced level. It resets to 0 on any cycle where they match. When the counter reaches DEBOUNCE_CYCLES−1 while still differing, the debounced level flips and the counter clears.
- Press pulse: a 1-cycle pulse (`enter_p`, `clear_p`) asserts the cycle after the debounced level goes 1→0. Release generates no pulse.
- FSM states:
  - COLLECT (reset state): collecting digits.
  - OFFER: `value_valid` = 1.
- COLLECT behaviour, evaluated in this order each cycle:
  - `clear_p`: acc ← 0, digit_count ← 0, digit_error ← 0. A clear takes priority over a simultaneous enter.
  - `enter_p` with synchronized sw > 9: the digit is ignored and digit_error ← 1.
  - `enter_p` with sw ≤ 9:
    - acc ← acc×10 + sw (32-bit unsigned; no overflow possible within the legal DIGITS range).
    - digit_count ← digit_count+1.
    - digit_error ← 0.
    - If the new count equals DIGITS: value ← new acc, then go to OFFER.
- OFFER behaviour:
  - `value` and `value_valid` are held stable until `value_valid && value_ready`.
  - On transfer: acc ← 0, digit_count ← 0, go to COLLECT, `value_valid` ← 0 at the next edge.
  - `enter_p` and `clear_p` are ignored in OFFER; a key pressed during OFFER is lost, not queued.
  - `value_ready` is ignored in COLLECT.
- `entry_value` always equals acc. In OFFER, acc still holds the final value until the transfer.
- Reset values:
  - value = 0, value_valid = 0, entry_value = 0, digit_count = 0, digit_error = 0, state = COLLECT.
  - Debounced key levels = 1 (released); debounce counters = 0; synchronizer flops = 1 for keys, 0 for sw.
- Reset mid-operation: a partial entry and any pending offer are discarded immediately. The asynchronous assertion drops `value_valid` without a handshake.

## Timing
- Key latency, counting from the first clk edge that samples the new level:
  - 2 cycles through the synchronizer.
  - DEBOUNCE_CYCLES cycles to flip the debounced level.
  - 1 cycle to produce the pulse.
  - 1 edge for the FSM to update acc / digit_count / value_valid.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- `sw` is sampled from its synchronized copy in the same cycle as `enter_p`. It must be stable for at least 3 cycles before the debounced press completes.
- Handshake: `value_valid` never depends combinationally on `value_ready`. Back-to-back entries need at least one COLLECT cycle between them.
- With `value_ready` tied high, OFFER lasts exactly 1 cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, DIGITS = 2, `value_ready` = 1 unless noted.
- Basic entry:
  - Stimulus: sw = 4, press enter; then sw = 2, press enter.
  - Response: entry_value goes 0→4→42, digit_count goes 0→1→2, and value = 42 with `value_valid` high for exactly 1 cycle.
- Bounce rejection:
  - Stimulus: toggle key_enter_n low/high with a 2-cycle period for 20 cycles, then hold it low.
  - Response: exactly one digit is accepted.
- Invalid digit:
  - Stimulus: sw = 12, press enter.
  - Response: digit_error = 1, digit_count stays 0. A following press with sw = 7 accepts the digit and clears digit_error.
- Backpressure:
  - Stimulus: `value_ready` = 0; enter 9 then 9; press enter again during OFFER; raise `value_ready` after 50 cycles.
  - Response: value stays 99 with `value_valid` high throughout; the extra press is ignored; after the handshake, digit_count = 0 and entry_value = 0.
- Clear priority:
  - Stimulus: after one accepted digit (3), press clear and enter so that both pulses coincide.
  - Response: entry_value = 0, digit_count = 0, and no digit is accepted.
- Reset mid-offer:
  - Stimulus: assert rst_n = 0 while `value_valid` = 1 and `value_ready` = 0.
  - Response: `value_valid` drops asynchronously; all outputs read 0 and state = COLLECT.
